axi_wr_burst_sched: RTL and testbench
=====================================

# axi_wr_burst_sched

Write burst scheduler in front of the AXI write state core. Accepts one linear transfer command (start address, total beat count), splits it into AXI INCR bursts that never exceed MAX_BURST beats nor cross a 4 KB page, and sequences them one at a time through the core's write_req/req_resp/req_done handshake. Reports whole-transfer completion and aborts on a bus-error response. One scheduler instance serves one write core.

## Interface
- ASIZE, 32: address width.
- LSIZE, 10: core burst-length field width; must satisfy MAX_BURST ≤ 2^LSIZE−1.
- CSIZE, 24: command beat-count width.
- MAX_BURST, 64: maximum beats per burst, 1..128.
- Beat size is fixed at 32 bytes, matching the core's awsize 3'b101. A 4 KB page therefore holds 128 beats.

Ports:
- axi_aclk  in  1  clock.
- axi_resetn  in  1  reset; synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  scheduler idle and able to accept a command.
- cmd_addr  in  ASIZE  start byte address. Bits [4:0] are ignored and forced to 0.
- cmd_beats  in  CSIZE  total beats to transfer; 0 is legal.
- busy  out  1  command in progress.
- xfer_done  out  1  one-cycle pulse: all bursts completed with OKAY response.
- xfer_err  out  1  one-cycle pulse: a burst ended without req_done, and the command was abandoned.
- err_addr  out  ASIZE  address of the failing burst; valid from the xfer_err pulse until the next accepted command.
- write_req  out  1  burst request to the core.
- req_len  out  LSIZE  burst length in beats (1..MAX_BURST).
- req_addr  out  ASIZE  burst start byte address.
- req_resp  in  1  core accepted the request; core has entered its address phase.
- req_done  in  1  core pulse: burst finished, OKAY response.
- core_pend  in  1  core's pend_out; high while the core is busy.

## Operation
States: IDLE, CALC, REQ, WAIT, FIN.

- **IDLE**
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch addr = {cmd_addr[ASIZE-1:5], 5'b0} and rem = cmd_beats, then go to CALC.
- **CALC** (one cycle)
  - If rem==0, go to FIN.
  - Otherwise compute:
    - page = 128 − addr[11:5], giving 1..128;
    - len = min(rem, MAX_BURST, page).
  - Register req_len = len and req_addr = addr, then go to REQ.
- **REQ**
  - write_req=1; hold it until req_resp is sampled high.
  - On that cycle go to WAIT. write_req is 0 from the next cycle.
- **WAIT**
  - If req_done=1:
    - addr += len·32 and rem −= len;
    - if the new rem==0 go to FIN, else go to CALC.
  - Else, if core_pend falls (registered core_pend_d=1, core_pend=0) while req_done=0:
    - xfer_err=1;
    - err_addr = req_addr;
    - go to IDLE;
    - remaining beats are discarded.
- **FIN**: xfer_done=1 for one cycle, then IDLE.

General rules:
- busy = (state≠IDLE).
- req_len and req_addr change only in CALC. They stay stable through REQ and WAIT, because the core re-samples req_len every cycle.
- Address arithmetic wraps modulo 2^ASIZE.
- rem never underflows, since len ≤ rem.
- If req_done and a core_pend fall coincide in the same cycle, the result is success (done has priority).
- cmd_valid outside IDLE is ignored; cmd_ready=0 there.

## Timing
- Reset (axi_resetn=0 at a clock edge):
  - state=IDLE, so cmd_ready=1;
  - busy, write_req, xfer_done, xfer_err = 0;
  - req_len, req_addr, err_addr, rem, addr = 0.
- Reset mid-transfer drops write_req on the next edge. The command is lost and no pulse is generated.
- All outputs are registered.
- Command handshake at edge T:
  - CALC at T+1;
  - write_req=1 from T+2;
  - with zero beats, xfer_done=1 at T+2 and cmd_ready=1 at T+3.
- write_req falls on the edge after req_resp is sampled high. The core never sees write_req when it returns to its idle state.
- From req_done at edge D:
  - the next burst's write_req is high at D+2;
  - or xfer_done is high at D+1 if that was the last burst.
- Error detection latency: xfer_err is high one cycle after core_pend falls.

## Test plan
- **Single burst**: cmd_addr=0x0, cmd_beats=16. Expect:
  - exactly one write_req, with req_len=16 and req_addr=0x0;
  - xfer_done pulses one cycle after req_done.
- **Page split**: cmd_addr=0x1F00, cmd_beats=200. Expect bursts (len@addr):
  - 8@0x1F00;
  - 64@0x2000;
  - 64@0x2800;
  - 64@0x3000;
  - then a single xfer_done.
- **Zero length**: cmd_beats=0. Expect no write_req, xfer_done at T+2, and cmd_ready high again at T+3.
- **Backpressure**: req_resp delayed 5 cycles after write_req. Expect:
  - write_req held for those 5 cycles;
  - req_len/req_addr unchanged until req_done;
  - cmd_valid pulses during the transfer ignored.
- **Bus error**: cmd_beats=200 at 0x1F00, with the second burst ending with a core_pend fall and no req_done. Expect:
  - xfer_err=1, err_addr=0x2000;
  - no further write_req;
  - no xfer_done;
  - cmd_ready=1 the next cycle.
- **Reset mid-transfer**: assert axi_resetn=0 while in WAIT. Expect:
  - all outputs at reset values after the edge;
  - a new 16-beat command after release completes normally.

Source files
------------

// File: rtl/axi_wr_burst_sched.sv
// Splits one linear write command into page-safe INCR bursts of at most MAX_BURST
// 32-byte beats and sequences them through the write core one at a time.
module axi_wr_burst_sched #(
  parameter int ASIZE     = 32,
  parameter int LSIZE     = 10,
  parameter int CSIZE     = 24,
  parameter int MAX_BURST = 64
) (
  input  logic             axi_aclk,
  input  logic             axi_resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ASIZE-1:0] cmd_addr,
  input  logic [CSIZE-1:0] cmd_beats,
  output logic             busy,
  output logic             xfer_done,
  output logic             xfer_err,
  output logic [ASIZE-1:0] err_addr,
  output logic             write_req,
  output logic [LSIZE-1:0] req_len,
  output logic [ASIZE-1:0] req_addr,
  input  logic             req_resp,
  input  logic             req_done,
  input  logic             core_pend
);

  typedef enum logic [2:0] {IDLE, CALC, REQ, WAIT, FIN} state_t;

  state_t           state;
  logic [ASIZE-1:0] addr;
  logic [CSIZE-1:0] rem;
  logic             core_pend_d;

  // Burst length limited by remaining beats, MAX_BURST and beats left in the 4 KB page.
  function automatic logic [LSIZE-1:0] burst_len(input logic [6:0]       pg_off,
                                                 input logic [CSIZE-1:0] r);
    logic [7:0]       page;
    logic [CSIZE-1:0] lim;
    page = 8'd128 - {1'b0, pg_off};
    lim  = r;
    if (lim > CSIZE'(MAX_BURST)) lim = CSIZE'(MAX_BURST);
    if (lim > CSIZE'(page))      lim = CSIZE'(page);
    return LSIZE'(lim);
  endfunction

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      write_req   <= 1'b0;
      xfer_done   <= 1'b0;
      xfer_err    <= 1'b0;
      req_len     <= '0;
      req_addr    <= '0;
      err_addr    <= '0;
      rem         <= '0;
      addr        <= '0;
      core_pend_d <= 1'b0;
    end else begin
      core_pend_d <= core_pend;
      xfer_done   <= 1'b0;
      xfer_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr      <= cmd_addr & ~ASIZE'(31);
            rem       <= cmd_beats;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= CALC;
          end
        end
        CALC: begin
          if (rem == '0) begin
            xfer_done <= 1'b1;
            state     <= FIN;
          end else begin
            req_len   <= burst_len(addr[11:5], rem);
            req_addr  <= addr;
            write_req <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (req_resp) begin
            write_req <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // A completed burst wins over a coincident core_pend fall.
          if (req_done) begin
            addr <= addr + (ASIZE'(req_len) << 5);
            rem  <= rem - CSIZE'(req_len);
            if (rem == CSIZE'(req_len)) begin
              xfer_done <= 1'b1;
              state     <= FIN;
            end else begin
              state <= CALC;
            end
          end else if (core_pend_d && !core_pend) begin
            xfer_err  <= 1'b1;
            err_addr  <= req_addr;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        FIN: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          write_req <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_burst_sched.sv
// Directed and randomized bench for axi_wr_burst_sched with a simple core model
// and an arithmetic reference of the expected burst sequence.
module tb_axi_wr_burst_sched;

  localparam int MAXB = 64;

  logic        axi_aclk = 1'b0;
  logic        axi_resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [23:0] cmd_beats;
  logic        busy;
  logic        xfer_done;
  logic        xfer_err;
  logic [31:0] err_addr;
  logic        write_req;
  logic [9:0]  req_len;
  logic [31:0] req_addr;
  logic        req_resp;
  logic        req_done;
  logic        core_pend;

  int checks = 0;
  int errors = 0;

  int          exp_len[$];
  logic [31:0] exp_addr[$];

  axi_wr_burst_sched #(.ASIZE(32), .LSIZE(10), .CSIZE(24), .MAX_BURST(MAXB)) dut (
    .axi_aclk  (axi_aclk),
    .axi_resetn(axi_resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_beats (cmd_beats),
    .busy      (busy),
    .xfer_done (xfer_done),
    .xfer_err  (xfer_err),
    .err_addr  (err_addr),
    .write_req (write_req),
    .req_len   (req_len),
    .req_addr  (req_addr),
    .req_resp  (req_resp),
    .req_done  (req_done),
    .core_pend (core_pend)
  );

  always #5 axi_aclk = ~axi_aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected burst list: walk the transfer, cutting at MAXB beats and 4 KB boundaries.
  function automatic void model(input logic [31:0] a0, input int beats);
    longint a, rem, page, len;
    exp_len.delete();
    exp_addr.delete();
    a   = longint'(a0) & 64'hFFFF_FFE0;
    rem = beats;
    while (rem > 0) begin
      page = 128 - ((a % 4096) / 32);
      len  = rem;
      if (len > MAXB) len = MAXB;
      if (len > page) len = page;
      exp_len.push_back(int'(len));
      exp_addr.push_back(a[31:0]);
      a   = (a + len * 32) % 64'h1_0000_0000;
      rem = rem - len;
    end
  endfunction

  task automatic run_cmd(input logic [31:0] a, input int beats, input int resp_dly,
                         input int done_dly, input int err_idx, input bit inject);
    int n;
    model(a, beats);
    chk("idle_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_beats = beats[23:0];
    tick();
    cmd_valid = 1'b0;
    chk("acc_ready", cmd_ready, 0);
    chk("acc_busy", busy, 1);
    if (exp_len.size() == 0) begin
      tick();
      chk("zero_done", xfer_done, 1);
      chk("zero_wreq", write_req, 0);
      tick();
      chk("zero_done_clr", xfer_done, 0);
      chk("zero_ready", cmd_ready, 1);
      return;
    end
    for (int i = 0; i < exp_len.size(); i++) begin
      n = 0;
      while (write_req !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      chk("wreq_latency", n, 1);
      if (write_req !== 1'b1) return;
      chk("req_len", req_len, exp_len[i]);
      chk("req_addr", req_addr, exp_addr[i]);
      for (int k = 0; k < resp_dly; k++) begin
        if (inject) begin
          cmd_valid = 1'b1;
          cmd_addr  = $urandom;
          cmd_beats = 24'($urandom);
        end
        tick();
        chk("wreq_hold", write_req, 1);
        chk("len_hold", req_len, exp_len[i]);
        chk("addr_hold", req_addr, exp_addr[i]);
        chk("ready_low", cmd_ready, 0);
      end
      cmd_valid = 1'b0;
      req_resp  = 1'b1;
      core_pend = 1'b1;
      tick();
      req_resp = 1'b0;
      chk("wreq_drop", write_req, 0);
      for (int k = 0; k < done_dly; k++) begin
        tick();
        chk("wreq_wait", write_req, 0);
        chk("len_wait", req_len, exp_len[i]);
        chk("addr_wait", req_addr, exp_addr[i]);
      end
      if (i == err_idx) begin
        core_pend = 1'b0;
        tick();
        chk("err_pulse", xfer_err, 1);
        chk("err_addr", err_addr, exp_addr[i]);
        chk("err_ready", cmd_ready, 1);
        chk("err_busy", busy, 0);
        chk("err_no_done", xfer_done, 0);
        tick();
        chk("err_clr", xfer_err, 0);
        for (int k = 0; k < 3; k++) begin
          chk("err_no_wreq", write_req, 0);
          chk("err_no_done2", xfer_done, 0);
          tick();
        end
        return;
      end
      req_done  = 1'b1;
      core_pend = 1'b0;
      tick();
      req_done = 1'b0;
      chk("no_err", xfer_err, 0);
      if (i == exp_len.size() - 1) begin
        chk("done_pulse", xfer_done, 1);
        chk("done_wreq", write_req, 0);
        tick();
        chk("done_clr", xfer_done, 0);
        chk("done_ready", cmd_ready, 1);
        chk("done_busy", busy, 0);
      end else begin
        chk("mid_no_done", xfer_done, 0);
      end
    end
  endtask

  initial begin
    axi_resetn = 1'b0;
    cmd_valid  = 1'b0;
    cmd_addr   = '0;
    cmd_beats  = '0;
    req_resp   = 1'b0;
    req_done   = 1'b0;
    core_pend  = 1'b0;
    tick();
    tick();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wreq", write_req, 0);
    chk("rst_done", xfer_done, 0);
    chk("rst_err", xfer_err, 0);
    chk("rst_len", req_len, 0);
    chk("rst_addr", req_addr, 0);
    chk("rst_err_addr", err_addr, 0);
    axi_resetn = 1'b1;
    tick();

    // single burst, page split, zero length
    run_cmd(32'h0000_0000, 16, 0, 2, -1, 1'b0);
    run_cmd(32'h0000_1F00, 200, 1, 1, -1, 1'b0);
    run_cmd(32'h0000_0040, 0, 0, 0, -1, 1'b0);
    // backpressure with ignored command pulses
    run_cmd(32'h0000_0500, 100, 5, 3, -1, 1'b1);
    // bus error on the second burst
    run_cmd(32'h0000_1F00, 200, 0, 2, 1, 1'b0);

    // reset while waiting for a burst to finish
    model(32'h0000_0100, 40);
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_0100;
    cmd_beats = 24'd40;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("mr_wreq", write_req, 1);
    chk("mr_addr", req_addr, exp_addr[0]);
    req_resp  = 1'b1;
    core_pend = 1'b1;
    tick();
    req_resp = 1'b0;
    tick();
    axi_resetn = 1'b0;
    core_pend  = 1'b0;
    tick();
    chk("mr_ready", cmd_ready, 1);
    chk("mr_busy", busy, 0);
    chk("mr_wreq0", write_req, 0);
    chk("mr_done", xfer_done, 0);
    chk("mr_err", xfer_err, 0);
    chk("mr_len", req_len, 0);
    chk("mr_raddr", req_addr, 0);
    chk("mr_err_addr", err_addr, 0);
    axi_resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mr_quiet_done", xfer_done, 0);
      chk("mr_quiet_wreq", write_req, 0);
    end
    run_cmd(32'h0000_0040, 16, 1, 1, -1, 1'b0);

    // randomized commands, including addresses near the top of the address space
    for (int r = 0; r < 12; r++) begin
      logic [31:0] ra;
      ra = $urandom;
      if (r % 4 == 3) ra = 32'hFFFF_F000 | (ra & 32'h0000_0FFF);
      run_cmd(ra, $urandom_range(0, 300), $urandom_range(0, 3), $urandom_range(0, 3),
              (r % 3 == 1) ? int'($urandom_range(0, 5)) : -1, r[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
